// File: rtl/grid_adc_avg_pkg.sv
// grid_adc_pkg: constants and types shared by the grid_adc_avg block.
//   - control/status register word addresses and identification values
//   - accumulator sizing (24 bits holds 256 full-scale 16-bit samples)
//   - beat_t: one finished average as presented on the streaming source
//   - clampLog2(): limits the programmed window exponent to MAX_LOG2
package grid_adc_pkg;

  localparam logic [3:0]  ADDR_SIZE  = 4'd0;
  localparam logic [3:0]  ADDR_ID    = 4'd1;
  localparam logic [3:0]  ADDR_CTRL  = 4'd2;
  localparam logic [3:0]  ADDR_MASK  = 4'd3;
  localparam logic [3:0]  ADDR_COUNT = 4'd4;

  localparam logic [31:0] REG_SIZE   = 32'd64;
  localparam logic [31:0] MODULE_ID  = 32'hEA68_0004;

  localparam int          MAX_LOG2   = 8;
  localparam int          ACC_W      = 24;
  localparam int          NUM_CH     = 16;

  typedef struct packed {
    logic [3:0]  channel;
    logic [15:0] data;
  } beat_t;

  function automatic logic [3:0] clampLog2(input logic [3:0] raw);
    return (raw > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : raw;
  endfunction

endpackage

// File: rtl/grid_adc_avg_if.sv
// grid_adc_avg_if: bundles the three buses of the averager.
//   avs_ctrl_* : Avalon-MM control/status slave (address, writedata,
//                byteenable, write, read in; readdata, waitrequest out)
//   asi_adc_*  : Avalon-ST sink carrying {channel, left-justified sample}
//   aso_avg_*  : Avalon-ST source carrying {channel, average}
// Modport slave is the averager's view, master is the surrounding system.
interface grid_adc_avg_if;

  logic [3:0]  avs_ctrl_address;
  logic [31:0] avs_ctrl_writedata;
  logic [3:0]  avs_ctrl_byteenable;
  logic        avs_ctrl_write;
  logic        avs_ctrl_read;
  logic [31:0] avs_ctrl_readdata;
  logic        avs_ctrl_waitrequest;

  logic [3:0]  asi_adc_channel;
  logic [15:0] asi_adc_data;
  logic        asi_adc_valid;
  logic        asi_adc_ready;

  logic [3:0]  aso_avg_channel;
  logic [15:0] aso_avg_data;
  logic        aso_avg_valid;
  logic        aso_avg_ready;

  modport slave (
    input  avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
    input  avs_ctrl_write, avs_ctrl_read,
    output avs_ctrl_readdata, avs_ctrl_waitrequest,
    input  asi_adc_channel, asi_adc_data, asi_adc_valid,
    output asi_adc_ready,
    output aso_avg_channel, aso_avg_data, aso_avg_valid,
    input  aso_avg_ready
  );

  modport master (
    output avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
    output avs_ctrl_write, avs_ctrl_read,
    input  avs_ctrl_readdata, avs_ctrl_waitrequest,
    output asi_adc_channel, asi_adc_data, asi_adc_valid,
    input  asi_adc_ready,
    input  aso_avg_channel, aso_avg_data, aso_avg_valid,
    output aso_avg_ready
  );

endinterface

// File: rtl/grid_adc_avg_chan.sv
// grid_adc_avg_chan: one channel's boxcar slice.
//   clk, rst_n   : clock, asynchronous active-low reset
//   sample_i     : a sample for this channel is being consumed this cycle
//   data_i       : the sample value
//   log2_i       : window exponent, already limited to MAX_LOG2
//   flush_i      : discard the partial window (acc/cnt to zero)
//   clear_i      : also zero the published result
//   done_o       : this sample closes the window
//   avg_next_o   : average produced when done_o is high
//   avg_o        : last published average
module grid_adc_avg_chan
  import grid_adc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_i,
  input  logic [15:0] data_i,
  input  logic [3:0]  log2_i,
  input  logic        flush_i,
  input  logic        clear_i,
  output logic        done_o,
  output logic [15:0] avg_next_o,
  output logic [15:0] avg_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      avg_q, avg_d;
  logic [ACC_W-1:0] sum;
  logic [8:0]       lastIdx;

  assign sum        = acc_q + ACC_W'(data_i);
  assign lastIdx    = (9'd1 << log2_i) - 9'd1;
  assign done_o     = sample_i && ({1'b0, cnt_q} == lastIdx);
  assign avg_next_o = 16'(sum >> log2_i);
  assign avg_o      = avg_q;

  // A flush overrides accumulation so the next window starts empty even
  // when a sample arrives in the same cycle as a configuration change.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    avg_d = avg_q;
    if (sample_i) begin
      if (done_o) begin
        acc_d = '0;
        cnt_d = '0;
        avg_d = avg_next_o;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 8'd1;
      end
    end
    if (flush_i) begin
      acc_d = '0;
      cnt_d = '0;
    end
    if (clear_i) begin
      avg_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      avg_q <= avg_d;
    end
  end

endmodule

// File: rtl/grid_adc_avg.sv
// grid_adc_avg: 16-channel boxcar averager behind the AD7490 sampler.
//   csi_MCLK_clk      : sole clock
//   rsi_MRST_reset_n  : asynchronous active-low reset
//   bus (slave)       : control/status registers, sample sink, average source
// Holds the register file, the single-entry source register and the
// per-channel slices. Samples of masked channels are consumed and dropped.
module grid_adc_avg
  import grid_adc_pkg::*;
(
  input  logic          csi_MCLK_clk,
  input  logic          rsi_MRST_reset_n,
  grid_adc_avg_if.slave bus
);

  logic        enable_q, enable_d;
  logic [3:0]  log2_q, log2_d;
  logic [15:0] mask_q, mask_d;
  logic [31:0] count_q, count_d;
  logic [31:0] readdata_q, readdata_d;
  logic        valid_q, valid_d;
  beat_t       beat_q, beat_d;

  logic        ctrlWr, maskWr, clearPulse, flush;
  logic        sinkReady, accept, process, anyDone;
  logic [3:0]  effLog2;
  logic [15:0] sampleVec, doneVec;
  logic [15:0] avgVec  [NUM_CH];
  logic [15:0] avgNext [NUM_CH];
  logic        unusedBits;

  assign unusedBits = ^{bus.avs_ctrl_read, bus.avs_ctrl_writedata[31:16],
                        bus.avs_ctrl_writedata[15:12], bus.avs_ctrl_writedata[7:2],
                        bus.avs_ctrl_byteenable[3:2]};

  assign ctrlWr     = bus.avs_ctrl_write && (bus.avs_ctrl_address == ADDR_CTRL);
  assign maskWr     = bus.avs_ctrl_write && (bus.avs_ctrl_address == ADDR_MASK)
                      && (bus.avs_ctrl_byteenable[0] || bus.avs_ctrl_byteenable[1]);
  assign clearPulse = ctrlWr && bus.avs_ctrl_byteenable[0] && bus.avs_ctrl_writedata[1];
  // Any change to how a window is formed invalidates partial sums.
  assign flush      = clearPulse || maskWr
                      || (ctrlWr && bus.avs_ctrl_byteenable[1])
                      || (ctrlWr && bus.avs_ctrl_byteenable[0] && enable_q
                          && !bus.avs_ctrl_writedata[0]);

  assign effLog2    = clampLog2(log2_q);
  // While disabled every sample is swallowed, so the sampler never stalls.
  assign sinkReady  = !enable_q || !valid_q || bus.aso_avg_ready;
  assign accept     = bus.asi_adc_valid && sinkReady;
  // A clear in the same cycle discards the sample, so no beat can escape.
  assign process    = accept && enable_q && mask_q[bus.asi_adc_channel] && !clearPulse;
  assign anyDone    = |doneVec;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign sampleVec[k] = process && (bus.asi_adc_channel == 4'(k));
    grid_adc_avg_chan u_chan (
      .clk        (csi_MCLK_clk),
      .rst_n      (rsi_MRST_reset_n),
      .sample_i   (sampleVec[k]),
      .data_i     (bus.asi_adc_data),
      .log2_i     (effLog2),
      .flush_i    (flush),
      .clear_i    (clearPulse),
      .done_o     (doneVec[k]),
      .avg_next_o (avgNext[k]),
      .avg_o      (avgVec[k])
    );
  end

  // A completion can only occur when the source is free or being drained
  // this cycle, so loading the new beat never overwrites an untaken one.
  always_comb begin
    enable_d = enable_q;
    log2_d   = log2_q;
    mask_d   = mask_q;
    count_d  = count_q;
    valid_d  = valid_q;
    beat_d   = beat_q;
    if (ctrlWr && bus.avs_ctrl_byteenable[0]) enable_d = bus.avs_ctrl_writedata[0];
    if (ctrlWr && bus.avs_ctrl_byteenable[1]) log2_d = bus.avs_ctrl_writedata[11:8];
    if (maskWr && bus.avs_ctrl_byteenable[0]) mask_d[7:0] = bus.avs_ctrl_writedata[7:0];
    if (maskWr && bus.avs_ctrl_byteenable[1]) mask_d[15:8] = bus.avs_ctrl_writedata[15:8];
    if (clearPulse) begin
      count_d = '0;
    end else if (anyDone) begin
      count_d = count_q + 32'd1;
    end
    if (anyDone) begin
      valid_d        = 1'b1;
      beat_d.channel = bus.asi_adc_channel;
      beat_d.data    = avgNext[bus.asi_adc_channel];
    end else if (bus.aso_avg_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    readdata_d = '0;
    case (bus.avs_ctrl_address)
      ADDR_SIZE:  readdata_d = REG_SIZE;
      ADDR_ID:    readdata_d = MODULE_ID;
      ADDR_CTRL:  readdata_d = {20'd0, log2_q, 7'd0, enable_q};
      ADDR_MASK:  readdata_d = {16'd0, mask_q};
      ADDR_COUNT: readdata_d = count_q;
      default: begin
        if (bus.avs_ctrl_address[3]) begin
          readdata_d = {avgVec[{bus.avs_ctrl_address[2:0], 1'b1}],
                        avgVec[{bus.avs_ctrl_address[2:0], 1'b0}]};
        end
      end
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      enable_q   <= 1'b0;
      log2_q     <= '0;
      mask_q     <= 16'hFFFF;
      count_q    <= '0;
      readdata_q <= '0;
      valid_q    <= 1'b0;
      beat_q     <= '0;
    end else begin
      enable_q   <= enable_d;
      log2_q     <= log2_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
      valid_q    <= valid_d;
      beat_q     <= beat_d;
    end
  end

  assign bus.avs_ctrl_readdata    = readdata_q;
  assign bus.avs_ctrl_waitrequest = 1'b0;
  assign bus.asi_adc_ready        = sinkReady;
  assign bus.aso_avg_valid        = valid_q;
  assign bus.aso_avg_channel      = beat_q.channel;
  assign bus.aso_avg_data         = beat_q.data;

endmodule

// File: tb/tb_grid_adc_avg.sv
// tb_grid_adc_avg: self-checking bench for grid_adc_avg.
// A transaction-level model (per-channel running sums and sample counts,
// plain arithmetic) predicts the source register, sink ready and read data
// every cycle; directed scenarios pin the model with literal expectations,
// and a randomized phase exercises configuration churn and backpressure.
module tb_grid_adc_avg;
  import grid_adc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  grid_adc_avg_if bus();

  grid_adc_avg dut (
    .csi_MCLK_clk     (clk),
    .rsi_MRST_reset_n (rst_n),
    .bus              (bus)
  );

  int checks = 0;
  int failures = 0;

  bit          m_en;
  logic [3:0]  m_log2;
  logic [15:0] m_mask;
  logic [31:0] m_count;
  int          m_acc [16];
  int          m_cnt [16];
  logic [15:0] m_avg [16];
  bit          m_sv;
  logic [3:0]  m_sch;
  logic [15:0] m_sdata;
  logic [31:0] m_rd;

  logic [19:0] obsQ [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] regRead(input logic [3:0] a);
    int k;
    if (a >= 4'd8) begin
      k = int'(a) - 8;
      return {m_avg[2*k+1], m_avg[2*k]};
    end
    case (a)
      4'd0:    return 32'd64;
      4'd1:    return 32'hEA68_0004;
      4'd2:    return {20'd0, m_log2, 7'd0, m_en};
      4'd3:    return {16'd0, m_mask};
      4'd4:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    m_en = 0; m_log2 = '0; m_mask = 16'hFFFF; m_count = '0;
    for (int i = 0; i < 16; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_avg[i] = '0;
    end
    m_sv = 0; m_sch = '0; m_sdata = '0; m_rd = '0;
  endtask

  task automatic modelStep();
    bit rdy, ctrlW, maskW, clr, flushAll, beat;
    int c, n;
    logic [3:0]  be;
    logic [31:0] wd;
    be = bus.avs_ctrl_byteenable;
    wd = bus.avs_ctrl_writedata;
    m_rd  = regRead(bus.avs_ctrl_address);
    rdy   = !m_en || !m_sv || bus.aso_avg_ready;
    ctrlW = bus.avs_ctrl_write && bus.avs_ctrl_address == 4'd2;
    maskW = bus.avs_ctrl_write && bus.avs_ctrl_address == 4'd3 && (be[0] || be[1]);
    clr   = ctrlW && be[0] && wd[1];
    flushAll = clr || maskW || (ctrlW && be[1]) || (ctrlW && be[0] && m_en && !wd[0]);
    beat = 0;
    c = int'(bus.asi_adc_channel);
    if (bus.asi_adc_valid && rdy && m_en && m_mask[c] && !clr) begin
      n = (m_log2 > 4'd8) ? 8 : int'(m_log2);
      if (m_cnt[c] + 1 == (1 << n)) begin
        m_avg[c] = 16'((m_acc[c] + int'(bus.asi_adc_data)) / (1 << n));
        m_acc[c] = 0;
        m_cnt[c] = 0;
        beat = 1;
      end else begin
        m_acc[c] += int'(bus.asi_adc_data);
        m_cnt[c] += 1;
      end
    end
    if (beat) begin
      m_sv = 1; m_sch = bus.asi_adc_channel; m_sdata = m_avg[c]; m_count++;
    end else if (bus.aso_avg_ready) begin
      m_sv = 0;
    end
    if (ctrlW && be[0]) m_en = wd[0];
    if (ctrlW && be[1]) m_log2 = wd[11:8];
    if (maskW && be[0]) m_mask[7:0] = wd[7:0];
    if (maskW && be[1]) m_mask[15:8] = wd[15:8];
    if (flushAll) begin
      for (int i = 0; i < 16; i++) begin
        m_acc[i] = 0; m_cnt[i] = 0;
      end
    end
    if (clr) begin
      for (int i = 0; i < 16; i++) m_avg[i] = '0;
      m_count = '0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) modelReset();
    else modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      checkOutput("aso_avg_valid", 32'(bus.aso_avg_valid), 32'(m_sv));
      if (m_sv) begin
        checkOutput("aso_avg_channel", 32'(bus.aso_avg_channel), 32'(m_sch));
        checkOutput("aso_avg_data", 32'(bus.aso_avg_data), 32'(m_sdata));
      end
      checkOutput("asi_adc_ready", 32'(bus.asi_adc_ready),
                  32'(!m_en || !m_sv || bus.aso_avg_ready));
      checkOutput("avs_ctrl_readdata", bus.avs_ctrl_readdata, m_rd);
      checkOutput("avs_ctrl_waitrequest", 32'(bus.avs_ctrl_waitrequest), 32'd0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && bus.aso_avg_valid && bus.aso_avg_ready)
      obsQ.push_back({bus.aso_avg_channel, bus.aso_avg_data});
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ch, input logic [15:0] data);
    bit ok;
    ok = 0;
    bus.asi_adc_valid = 1'b1;
    bus.asi_adc_channel = ch;
    bus.asi_adc_data = data;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.asi_adc_ready;
      @(posedge clk); #1;
    end
    bus.asi_adc_valid = 1'b0;
    if (!ok) checkOutput("sink_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic writeReg(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.avs_ctrl_address = addr;
    bus.avs_ctrl_writedata = data;
    bus.avs_ctrl_byteenable = be;
    bus.avs_ctrl_write = 1'b1;
    @(posedge clk); #1;
    bus.avs_ctrl_write = 1'b0;
    bus.avs_ctrl_byteenable = 4'b0000;
  endtask

  task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
    bus.avs_ctrl_address = addr;
    bus.avs_ctrl_read = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    data = bus.avs_ctrl_readdata;
    @(posedge clk); #1;
    bus.avs_ctrl_read = 1'b0;
  endtask

  task automatic checkReg(input string name, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    readReg(addr, d);
    checkOutput(name, d, exp);
  endtask

  function automatic logic [31:0] beatAt(input int idx);
    if (idx < 0 || idx >= obsQ.size()) return 32'hDEAD_BEEF;
    return 32'(obsQ[idx]);
  endfunction

  initial begin
    int n0;
    logic [31:0] wd;
    logic [3:0]  be;
    bus.avs_ctrl_address = '0;
    bus.avs_ctrl_writedata = '0;
    bus.avs_ctrl_byteenable = '0;
    bus.avs_ctrl_write = 1'b0;
    bus.avs_ctrl_read = 1'b0;
    bus.asi_adc_channel = '0;
    bus.asi_adc_data = '0;
    bus.asi_adc_valid = 1'b0;
    bus.aso_avg_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 32'(bus.aso_avg_valid), 32'd0);
    checkOutput("reset_readdata", bus.avs_ctrl_readdata, 32'd0);
    checkOutput("reset_sink_ready", 32'(bus.asi_adc_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    checkReg("reg_size", 4'd0, 32'd64);
    checkReg("reg_id", 4'd1, 32'hEA68_0004);
    checkReg("reg_ctrl_reset", 4'd2, 32'h0000_0000);
    checkReg("reg_mask_reset", 4'd3, 32'h0000_FFFF);
    checkReg("reg_unmapped", 4'd5, 32'h0000_0000);

    // N=2 on channel 0 only
    $display("[TB] window of 4 on ch0");
    n0 = obsQ.size();
    writeReg(4'd3, 32'h0000_0001, 4'b0011);
    writeReg(4'd2, 32'h0000_0201, 4'b0011);
    applyStimulus(4'd0, 16'h1000);
    applyStimulus(4'd0, 16'h2000);
    applyStimulus(4'd0, 16'h3000);
    applyStimulus(4'd0, 16'h4000);
    idle(2);
    checkOutput("s1_beat_count", 32'(obsQ.size() - n0), 32'd1);
    checkOutput("s1_beat", beatAt(n0), 32'h0000_2800);
    checkReg("s1_reg8", 4'd8, 32'h0000_2800);
    checkReg("s1_reg4", 4'd4, 32'd1);
    checkReg("s1_ctrl", 4'd2, 32'h0000_0201);

    // N=0, back-to-back alternating channels
    $display("[TB] N=0 alternating ch3/ch4");
    n0 = obsQ.size();
    writeReg(4'd3, 32'h0000_0018, 4'b0011);
    writeReg(4'd2, 32'h0000_0001, 4'b0011);
    for (int i = 0; i < 4; i++) applyStimulus((i % 2 == 0) ? 4'd3 : 4'd4, 16'hFFF0);
    idle(2);
    checkOutput("s2_beat_count", 32'(obsQ.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("s2_beat", beatAt(n0 + i), (i % 2 == 0) ? 32'h0003_FFF0 : 32'h0004_FFF0);
    checkReg("s2_reg9", 4'd9, 32'hFFF0_0000);
    checkReg("s2_reg10", 4'd10, 32'h0000_FFF0);
    checkReg("s2_reg4", 4'd4, 32'd5);

    // N=8 full-scale on ch15
    $display("[TB] N=8 full scale ch15");
    n0 = obsQ.size();
    writeReg(4'd3, 32'h0000_8000, 4'b0011);
    writeReg(4'd2, 32'h0000_0801, 4'b0011);
    for (int i = 0; i < 256; i++) applyStimulus(4'd15, 16'hFFF0);
    idle(2);
    checkOutput("s3_beat_count", 32'(obsQ.size() - n0), 32'd1);
    checkOutput("s3_beat", beatAt(n0), 32'h000F_FFF0);
    checkReg("s3_reg15", 4'd15, 32'hFFF0_0000);
    checkReg("s3_reg4", 4'd4, 32'd6);

    // Backpressure on the source
    $display("[TB] source backpressure");
    writeReg(4'd3, 32'h0000_0001, 4'b0011);
    writeReg(4'd2, 32'h0000_0001, 4'b0011);
    bus.aso_avg_ready = 1'b0;
    applyStimulus(4'd0, 16'h1230);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("s4_hold_ready", 32'(bus.asi_adc_ready), 32'd0);
      checkOutput("s4_hold_valid", 32'(bus.aso_avg_valid), 32'd1);
      checkOutput("s4_hold_beat", {12'd0, bus.aso_avg_channel, bus.aso_avg_data}, 32'h0000_1230);
      @(posedge clk); #1;
    end
    bus.aso_avg_ready = 1'b1;
    @(negedge clk);
    checkOutput("s4_release_ready", 32'(bus.asi_adc_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("s4_taken_valid", 32'(bus.aso_avg_valid), 32'd0);
    @(posedge clk); #1;

    // Masked channel and mid-window reconfiguration
    $display("[TB] masked ch1, window change");
    n0 = obsQ.size();
    writeReg(4'd3, 32'h0000_FFFD, 4'b0011);
    writeReg(4'd2, 32'h0000_0101, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      bus.asi_adc_valid = 1'b1;
      bus.asi_adc_channel = 4'd1;
      bus.asi_adc_data = 16'h5550;
      @(negedge clk);
      checkOutput("s5_masked_ready", 32'(bus.asi_adc_ready), 32'd1);
      @(posedge clk); #1;
    end
    bus.asi_adc_valid = 1'b0;
    idle(2);
    checkOutput("s5_masked_no_beat", 32'(obsQ.size() - n0), 32'd0);
    checkReg("s5_reg8", 4'd8, 32'h0000_1230);
    applyStimulus(4'd0, 16'h8000);
    writeReg(4'd2, 32'h0000_0200, 4'b0010);
    applyStimulus(4'd0, 16'h1000);
    applyStimulus(4'd0, 16'h1000);
    applyStimulus(4'd0, 16'h2000);
    applyStimulus(4'd0, 16'h2000);
    idle(2);
    checkOutput("s5_beat_count", 32'(obsQ.size() - n0), 32'd1);
    checkOutput("s5_beat", beatAt(n0), 32'h0000_1800);
    checkReg("s5_reg8_new", 4'd8, 32'h0000_1800);

    // Clear
    $display("[TB] clear");
    writeReg(4'd2, 32'h0000_0003, 4'b0001);
    checkReg("clr_reg4", 4'd4, 32'd0);
    checkReg("clr_reg8", 4'd8, 32'd0);
    checkReg("clr_reg15", 4'd15, 32'd0);
    checkReg("clr_ctrl", 4'd2, 32'h0000_0201);

    // Randomized traffic, configuration churn and backpressure
    $display("[TB] random phase");
    writeReg(4'd3, 32'h0000_FFFF, 4'b0011);
    writeReg(4'd2, 32'h0000_0101, 4'b0011);
    for (int i = 0; i < 3000; i++) begin
      bus.asi_adc_valid = ($urandom_range(0, 3) != 0);
      bus.asi_adc_channel = 4'($urandom_range(0, 15));
      bus.asi_adc_data = 16'($urandom_range(0, 4095)) << 4;
      bus.aso_avg_ready = ($urandom_range(0, 3) != 0);
      bus.avs_ctrl_address = 4'($urandom_range(0, 15));
      bus.avs_ctrl_write = 1'b0;
      bus.avs_ctrl_byteenable = 4'b0000;
      if ($urandom_range(0, 39) == 0) begin
        int sel;
        sel = $urandom_range(0, 9);
        wd = 32'($urandom);
        be = 4'b1111;
        if (sel <= 4) begin
          int lc;
          lc = $urandom_range(0, 5);
          wd[11:8] = (lc <= 3) ? 4'(lc) : (lc == 4) ? 4'd8 : 4'($urandom_range(9, 15));
          wd[0] = ($urandom_range(0, 5) != 0);
          wd[1] = ($urandom_range(0, 7) == 0);
          case ($urandom_range(0, 3))
            0: be = 4'b0011;
            1: be = 4'b0001;
            2: be = 4'b0010;
            default: be = 4'b1111;
          endcase
          bus.avs_ctrl_address = 4'd2;
        end else if (sel <= 7) begin
          bus.avs_ctrl_address = 4'd3;
        end else if (sel == 8) begin
          bus.avs_ctrl_address = 4'd4;
        end else begin
          bus.avs_ctrl_address = 4'd0;
        end
        bus.avs_ctrl_writedata = wd;
        bus.avs_ctrl_byteenable = be;
        bus.avs_ctrl_write = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.asi_adc_valid = 1'b0;
    bus.avs_ctrl_write = 1'b0;
    bus.aso_avg_ready = 1'b1;
    idle(3);

    // Asynchronous reset with a beat pending
    $display("[TB] reset mid-beat");
    writeReg(4'd3, 32'h0000_0001, 4'b0011);
    writeReg(4'd2, 32'h0000_0001, 4'b0011);
    bus.aso_avg_ready = 1'b0;
    applyStimulus(4'd0, 16'h4560);
    bus.avs_ctrl_address = 4'd3;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(bus.aso_avg_valid), 32'd0);
    checkOutput("rst_readdata", bus.avs_ctrl_readdata, 32'd0);
    checkOutput("rst_sink_ready", 32'(bus.asi_adc_ready), 32'd1);
    idle(2);
    rst_n = 1'b1;
    bus.aso_avg_ready = 1'b1;
    checkReg("rst_ctrl", 4'd2, 32'h0000_0000);
    checkReg("rst_mask", 4'd3, 32'h0000_FFFF);
    checkReg("rst_count", 4'd4, 32'd0);
    checkReg("rst_reg8", 4'd8, 32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
